// File: rtl/hamming_seed_controller.sv
// Launch controller for the Hamming stream pipeline: holds CSR-programmed seeds, emits them
// as one Avalon-ST packet per run, then tracks the downstream busy pulse and counts runs.
module hamming_seed_controller #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned NUM_SEEDS      = 4,
  parameter int unsigned CSR_ADDR_WIDTH = 3
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic [WIDTH-1:0]          out_data,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_address,
  input  logic                      csr_read,
  input  logic                      csr_write,
  input  logic [WIDTH-1:0]          csr_writedata,
  output logic [WIDTH-1:0]          csr_readdata,
  input  logic                      busy
);

  localparam int unsigned IDX_W = (NUM_SEEDS > 1) ? $clog2(NUM_SEEDS) : 1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_SENDING   = 4'b0010,
    ST_WAIT_BUSY = 4'b0100,
    ST_BUSY      = 4'b1000
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        index;
  logic [IDX_W-1:0]        index_nxt;
  logic                    continuous;
  logic                    write_error;
  logic [WIDTH-1:0]        run_count;
  logic [WIDTH-1:0]        seed [NUM_SEEDS];

  logic                      ctrl_wr;
  logic                      start;
  logic                      abort;
  logic                      clr_err;
  logic                      seed_hit;
  logic                      seed_wr;
  logic [CSR_ADDR_WIDTH-1:0] seed_off;
  logic [IDX_W-1:0]          seed_sel;
  logic                      beat_done;
  logic                      last_beat;
  logic                      run_done;

  // CSR decode
  assign ctrl_wr   = csr_write && (csr_address == '0);
  assign start     = ctrl_wr && csr_writedata[0];
  assign abort     = ctrl_wr && csr_writedata[2];
  assign clr_err   = ctrl_wr && csr_writedata[3];
  assign seed_off  = csr_address - CSR_ADDR_WIDTH'(2);
  assign seed_sel  = IDX_W'(seed_off);
  assign seed_hit  = (csr_address >= CSR_ADDR_WIDTH'(2)) &&
                     (32'(csr_address) < 32'(NUM_SEEDS + 2));
  assign seed_wr   = csr_write && seed_hit;
  assign beat_done = out_valid && out_ready;
  assign last_beat = (index == IDX_W'(NUM_SEEDS - 1));

  // Next-state logic; abort never truncates a packet in flight
  always_comb begin
    state_nxt = state;
    index_nxt = index;
    run_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SENDING;
          index_nxt = '0;
        end
      end
      ST_SENDING: begin
        if (beat_done) begin
          if (last_beat) begin
            state_nxt = ST_WAIT_BUSY;
            index_nxt = '0;
          end else begin
            index_nxt = index + IDX_W'(1);
          end
        end
      end
      ST_WAIT_BUSY: begin
        if (abort)     state_nxt = ST_IDLE;
        else if (busy) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (!busy) begin
          run_done  = 1'b1;
          state_nxt = continuous ? ST_SENDING : ST_IDLE;
          index_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        index_nxt = '0;
      end
    endcase
  end

  // State, CSR registers and registered stream outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      index             <= '0;
      continuous        <= 1'b0;
      write_error       <= 1'b0;
      run_count         <= '0;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_data          <= '0;
      for (int i = 0; i < int'(NUM_SEEDS); i++) begin
        seed[i] <= WIDTH'(i + 1);
      end
    end else begin
      state             <= state_nxt;
      index             <= index_nxt;
      out_valid         <= (state_nxt == ST_SENDING);
      out_startofpacket <= (state_nxt == ST_SENDING) && (index_nxt == '0);
      out_endofpacket   <= (state_nxt == ST_SENDING) && (index_nxt == IDX_W'(NUM_SEEDS - 1));
      out_data          <= (state_nxt == ST_SENDING) ? seed[index_nxt] : '0;

      if (run_done) run_count <= run_count + WIDTH'(1);
      if (ctrl_wr)  continuous <= csr_writedata[1] && !csr_writedata[2];

      if (clr_err)                            write_error <= 1'b0;
      else if (seed_wr && state != ST_IDLE)   write_error <= 1'b1;

      if (seed_wr && state == ST_IDLE) seed[seed_sel] <= csr_writedata;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    csr_readdata = '0;
    if (csr_read) begin
      if (csr_address == '0)                    csr_readdata = WIDTH'({write_error, continuous, state});
      else if (csr_address == CSR_ADDR_WIDTH'(1)) csr_readdata = run_count;
      else if (seed_hit)                        csr_readdata = seed[seed_sel];
    end
  end

endmodule

// File: tb/tb_hamming_seed_controller.sv
// Scoreboard bench for hamming_seed_controller: stimulus queues expected beats and CSR reads,
// a negedge monitor pops and compares them.
module tb_hamming_seed_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        out_ready;
  logic        out_valid;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [31:0] out_data;
  logic [2:0]  csr_address;
  logic        csr_read;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;
  logic        busy;

  hamming_seed_controller #(.WIDTH(32), .NUM_SEEDS(4), .CSR_ADDR_WIDTH(3)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_data          (out_data),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_readdata      (csr_readdata),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } csr_exp_t;

  beat_t       exp_q [$];
  csr_exp_t    csr_q [$];
  logic [31:0] model_seed [4];
  int          tests = 0;
  int          fails = 0;
  logic        done  = 1'b0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: owns all comparison counters
  initial begin : monitor
    beat_t    got;
    beat_t    held;
    beat_t    e;
    csr_exp_t c;
    logic     held_pending = 1'b0;
    forever begin
      @(negedge clock);
      got = {out_data, out_startofpacket, out_endofpacket};
      if (!reset_n) begin
        held_pending = 1'b0;
        cmp("reset_outputs", 64'({out_valid, out_startofpacket, out_endofpacket, out_data}), 64'd0);
      end else begin
        if (held_pending) cmp("hold_stable", 64'({out_valid, got}), 64'({1'b1, held}));
        held_pending = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            cmp("unexpected_beat", 64'(got), 64'd0 - 64'd1);
          end else begin
            e = exp_q.pop_front();
            cmp("beat", 64'(got), 64'(e));
          end
        end else if (out_valid) begin
          held_pending = 1'b1;
          held         = got;
        end
      end
      if (csr_read) begin
        if (csr_q.size() == 0) begin
          cmp("unexpected_read", 64'(csr_readdata), 64'd0 - 64'd1);
        end else begin
          c = csr_q.pop_front();
          cmp(c.name, 64'(csr_readdata), 64'(c.val));
        end
      end
      if (done) begin
        cmp("beats_left", 64'(exp_q.size()), 64'd0);
        cmp("reads_left", 64'(csr_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    csr_write     = 1'b1;
    csr_address   = a;
    csr_writedata = d;
    tick();
    csr_write     = 1'b0;
  endtask

  // One-cycle read; the monitor compares it at the following negedge
  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    csr_exp_t c;
    c.name = nm;
    c.val  = exp;
    csr_q.push_back(c);
    csr_read    = 1'b1;
    csr_address = a;
    tick();
    csr_read    = 1'b0;
  endtask

  task automatic push_beats(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{data: model_seed[i], sop: (i == 0), eop: (i == 3)});
    end
  endtask

  task automatic busy_pulse(input int n);
    busy = 1'b1;
    repeat (n) tick();
    busy = 1'b0;
    tick();
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) model_seed[i] = 32'(i + 1);
  endtask

  initial begin : stimulus
    reset_n       = 1'b1;
    out_ready     = 1'b1;
    busy          = 1'b0;
    csr_address   = '0;
    csr_read      = 1'b0;
    csr_write     = 1'b0;
    csr_writedata = '0;
    reset_model();

    // 1: reset values
    #2 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    rd(3'd0, 32'h1, "status_reset");
    rd(3'd1, 32'h0, "runcount_reset");
    for (int i = 0; i < 4; i++) rd(3'(i + 2), 32'(i + 1), "seed_reset");
    rd(3'd6, 32'h0, "unmapped6");
    rd(3'd7, 32'h0, "unmapped7");

    // 2: program seeds, single packet, busy pulse of 5 cycles
    wr(3'd2, 32'hA); wr(3'd3, 32'hB); wr(3'd4, 32'hC); wr(3'd5, 32'hD);
    model_seed = '{32'hA, 32'hB, 32'hC, 32'hD};
    rd(3'd3, 32'hB, "seed1_written");
    wr(3'd1, 32'h99);
    rd(3'd1, 32'h0, "runcount_ro");
    rd(3'd0, 32'h1, "status_ro_no_err");
    push_beats(4);
    wr(3'd0, 32'h1);
    rd(3'd0, 32'h2, "status_sending");
    tick(); tick();
    rd(3'd0, 32'h2, "status_last_beat");
    rd(3'd0, 32'h4, "status_wait_busy");
    busy = 1'b1;
    tick();
    rd(3'd0, 32'h8, "status_busy");
    repeat (3) tick();
    busy = 1'b0;
    tick();
    rd(3'd0, 32'h1, "status_after_run");
    rd(3'd1, 32'h1, "runcount_1");

    // 3: out_ready toggling, packet takes 8 cycles
    push_beats(4);
    wr(3'd0, 32'h1);
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      out_ready = ~out_ready;
    end
    rd(3'd0, 32'h2, "status_toggle_c7");
    rd(3'd0, 32'h4, "status_toggle_c8");
    out_ready = 1'b1;
    busy_pulse(2);
    rd(3'd1, 32'h2, "runcount_2");

    // 4: continuous mode, abort during third BUSY
    push_beats(4);
    wr(3'd0, 32'h3);
    repeat (4) tick();
    for (int p = 0; p < 2; p++) begin
      push_beats(4);
      busy_pulse(2);
      repeat (4) tick();
    end
    busy = 1'b1;
    tick();
    wr(3'd0, 32'h4);
    busy = 1'b0;
    rd(3'd0, 32'h1, "status_after_abort");
    rd(3'd1, 32'h4, "runcount_after_abort");

    // 5: seed write while sending is dropped and flagged
    push_beats(4);
    wr(3'd0, 32'h1);
    wr(3'd3, 32'h55);
    rd(3'd0, 32'h22, "status_write_error");
    tick(); tick();
    busy_pulse(1);
    rd(3'd0, 32'h21, "status_err_sticky");
    rd(3'd3, 32'hB, "seed1_unchanged");
    wr(3'd0, 32'h8);
    rd(3'd0, 32'h1, "status_err_cleared");

    // 7: start+abort together, busy already high at WAIT_BUSY entry
    push_beats(4);
    wr(3'd0, 32'h7);
    rd(3'd0, 32'h2, "status_start_abort");
    busy = 1'b1;
    repeat (3) tick();
    rd(3'd0, 32'h4, "status_wait_prebusy");
    rd(3'd0, 32'h8, "status_busy_prebusy");
    busy = 1'b0;
    tick();
    rd(3'd0, 32'h1, "status_idle_noncont");
    rd(3'd1, 32'h6, "runcount_6");

    // 8: abort while sending completes the packet and stops continuous; start ignored in WAIT_BUSY
    push_beats(4);
    wr(3'd0, 32'h3);
    wr(3'd0, 32'h4);
    repeat (3) tick();
    wr(3'd0, 32'h1);
    rd(3'd0, 32'h4, "status_start_ignored");
    busy_pulse(1);
    rd(3'd0, 32'h1, "status_abort_sending");
    rd(3'd1, 32'h7, "runcount_7");

    // 6: async reset mid-packet after two beats
    push_beats(2);
    wr(3'd0, 32'h1);
    tick(); tick();
    #2 reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    reset_model();
    rd(3'd0, 32'h1, "status_post_reset");
    rd(3'd1, 32'h0, "runcount_post_reset");
    for (int i = 0; i < 4; i++) rd(3'(i + 2), model_seed[i], "seed_post_reset");

    done = 1'b1;
  end

endmodule
